// File: rtl/demux_load_distributor.sv
// Debounced push-button loader that writes switch data into one of two output banks,
// chosen either manually or by an alternating ping-pong toggle.
module demux_load_distributor #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    LOAD         = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  logic             clk;
  logic             rst_n;
  logic [1:0]       key_meta;
  logic [9:0]       sw_meta;
  logic [9:0]       sw_s;
  logic             key_s;
  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic             toggle;
  logic [WIDTH-1:0] bank_x;
  logic [WIDTH-1:0] bank_y;
  logic             last_dest;
  logic             busy;
  logic             load_c;
  logic             dest_c;
  logic             unused;

  assign clk   = CLOCK_50;
  assign rst_n = KEY[0];
  assign key_s = key_meta[1];

  // Two-flop synchronizers; the idle button level is 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 2'b11;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      key_meta <= {key_meta[0], KEY[1]};
      sw_meta  <= SW;
      sw_s     <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    dest_c     = sw_s[8] ? toggle : sw_s[9];
    unique case (state)
      IDLE:         if (!key_s) state_next = DEBOUNCE;
      DEBOUNCE: begin
        if (key_s)                                state_next = IDLE;
        else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) state_next = LOAD;
      end
      LOAD: begin
        load_c     = 1'b1;
        state_next = WAIT_RELEASE;
      end
      WAIT_RELEASE: if (key_s) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // Counter saturates at DEBOUNCE_CYCLES-1 because the FSM leaves DEBOUNCE there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (state == DEBOUNCE && !key_s && cnt != CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_x    <= '0;
      bank_y    <= '0;
      last_dest <= 1'b0;
      toggle    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (load_c) begin
        if (dest_c) bank_y <= WIDTH'(sw_s[3:0]);
        else        bank_x <= WIDTH'(sw_s[3:0]);
        last_dest <= dest_c;
        if (sw_s[8]) toggle <= ~toggle;
      end
    end
  end

  assign LEDR   = {busy, last_dest, 4'(bank_y), 4'(bank_x)};
  assign unused = &{1'b0, KEY[3:2], sw_s[7:4]};

endmodule

// File: tb/tb_demux_load_distributor.sv
// Directed bench for demux_load_distributor with a short debounce window.
module tb_demux_load_distributor;

  logic       clk;
  logic [3:0] key;
  logic [9:0] sw;
  logic [9:0] ledr;
  int         checks;
  int         errors;

  demux_load_distributor #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .SW      (sw),
    .LEDR    (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       mode;
    logic       sel;
    int         hold;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: LEDR=%h expected %h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // State after reset: X=0 Y=0 last=0 toggle=0
    vecs[0] = '{4'hA, 1'b0, 1'b0, 12,  10'h00A}; // manual to X
    vecs[1] = '{4'h2, 1'b0, 1'b0, 2,   10'h00A}; // glitch rejected
    vecs[2] = '{4'h9, 1'b0, 1'b1, 12,  10'h19A}; // manual to Y
    vecs[3] = '{4'h3, 1'b1, 1'b1, 12,  10'h093}; // ping-pong -> X, toggle 1
    vecs[4] = '{4'h5, 1'b1, 1'b0, 12,  10'h153}; // ping-pong -> Y, toggle 0
    vecs[5] = '{4'h7, 1'b1, 1'b0, 12,  10'h057}; // ping-pong -> X, toggle 1
    vecs[6] = '{4'h1, 1'b0, 1'b0, 12,  10'h051}; // manual X, toggle holds 1
    vecs[7] = '{4'h6, 1'b1, 1'b0, 100, 10'h161}; // long hold -> Y once, toggle 0
    vecs[8] = '{4'h4, 1'b1, 1'b1, 12,  10'h064}; // ping-pong -> X

    key = 4'b1101;
    sw  = 10'h3FF;
    #1;
    key[0] = 1'b0;
    #2;
    check("reset_async", ledr, 10'h000);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("reset_hold", ledr, 10'h000);
    end

    // Key still held at reset release is a fresh press; SW=3FF means ping-pong data F
    key[0] = 1'b1;
    tick(12);
    check("press_through_reset", ledr, 10'h20F);
    key[1] = 1'b1;
    tick(6);
    check("press_through_reset_release", ledr, 10'h00F);

    key[0] = 1'b0;
    #1;
    check("reset_clears_banks", ledr, 10'h000);
    sw  = 10'h000;
    key = 4'b1110;
    tick(2);
    key[0] = 1'b1;
    tick(12);
    check("clean_release_no_load", ledr, 10'h000);

    for (int i = 0; i < 9; i++) begin
      sw = {vecs[i].sel, vecs[i].mode, 4'h0, vecs[i].data};
      tick(3);
      key[1] = 1'b0;
      tick(vecs[i].hold);
      if (vecs[i].hold >= 12)
        check($sformatf("vec%0d_held", i), ledr, vecs[i].exp | 10'h200);
      key[1] = 1'b1;
      tick(12);
      check($sformatf("vec%0d_done", i), ledr, vecs[i].exp);
    end

    // Load timing window, then select/mode/data changes after LOAD must be ignored
    sw = {1'b0, 1'b0, 4'h0, 4'h8};
    tick(3);
    key[1] = 1'b0;
    tick(6);
    check("latency_before_load", ledr, 10'h264);
    tick(3);
    check("latency_after_load", ledr, 10'h268);
    sw = {1'b1, 1'b1, 4'h0, 4'hF};
    tick(5);
    check("late_switch_change_held", ledr, 10'h268);
    key[1] = 1'b1;
    tick(8);
    check("late_switch_change_done", ledr, 10'h068);

    // Reset asserted on the third debounce cycle
    sw = {1'b0, 1'b0, 4'h0, 4'hB};
    tick(3);
    key[1] = 1'b0;
    tick(5);
    check("mid_debounce_busy", ledr, 10'h268);
    key[0] = 1'b0;
    #1;
    check("mid_debounce_reset", ledr, 10'h000);
    key[1] = 1'b1;
    tick(2);
    key[0] = 1'b1;
    tick(12);
    check("mid_debounce_no_load", ledr, 10'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
